// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII receive path.
// Imported by every module in the ether_* slice.
package ether_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    BODY,
    DROP
  } rx_state_t;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;
  localparam int         ETH_MAX_DIBITS = 6088;

endpackage

// File: rtl/ether_rx.sv
// RMII receive front end: preamble/SFD lock, body forwarding,
// oversize truncation and end-of-frame pulses.
module ether_rx
  import ether_pkg::*;
#(
  parameter int PREAMBLE_MIN = 28,
  parameter int MAX_DIBITS   = ETH_MAX_DIBITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int PW = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0] PRE_MIN  = PW'(PREAMBLE_MIN);
  localparam logic [12:0]   BODY_MAX = 13'(MAX_DIBITS);
  localparam logic [12:0]   BODY_SAT = '1;

  rx_state_t   state, state_n;
  logic [PW-1:0] pre_cnt, pre_n;
  logic [12:0] body_cnt, body_n;
  logic        v_n, done_n, err_n;
  logic [1:0]  d_n;

  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    body_n  = body_cnt;
    v_n     = 1'b0;
    d_n     = 2'b00;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (crsdv) begin
          if (rxd == PREAMBLE_DIBIT) begin
            state_n = PREAMBLE;
            pre_n   = PW'(1);
          end else begin
            state_n = DROP;
          end
        end
      end
      PREAMBLE: begin
        unique case (1'b1)
          !crsdv: state_n = IDLE;
          crsdv && rxd == PREAMBLE_DIBIT: begin
            if (pre_cnt < PRE_MIN)
              pre_n = pre_cnt + PW'(1);
          end
          crsdv && rxd == SFD_DIBIT
            && pre_cnt >= PRE_MIN: begin
            state_n = BODY;
            body_n  = '0;
          end
          default: begin
            state_n = DROP;
            err_n   = 1'b1;
          end
        endcase
      end
      BODY: begin
        unique case (1'b1)
          !crsdv: begin
            state_n = IDLE;
            done_n  = (body_cnt != '0);
          end
          // body_cnt == MAX means this dibit would be one too many
          crsdv && body_cnt >= BODY_MAX: begin
            state_n = DROP;
            err_n   = 1'b1;
          end
          default: begin
            v_n = 1'b1;
            d_n = rxd;
            if (body_cnt != BODY_SAT)
              body_n = body_cnt + 13'd1;
          end
        endcase
      end
      DROP: begin
        if (!crsdv)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      body_cnt   <= '0;
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      pre_cnt    <= pre_n;
      body_cnt   <= body_n;
      axiov      <= v_n;
      axiod      <= d_n;
      frame_done <= done_n;
      frame_err  <= err_n;
    end
  end

endmodule
